// File: rtl/inv_shift_rows_serial.sv
// Column-serial (Inv)ShiftRows: buffers each 4-column AES state block in a
// ping-pong bank pair and emits the row-rotated columns one per beat.
module inv_shift_rows_serial #(
  parameter bit INVERSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] col_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] col_out,
  output logic        out_last
);

  localparam int unsigned COL_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned NBANK  = 2;

  logic [COL_W-1:0] bank [NBANK][ROWS];
  logic [NBANK-1:0] full;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       wr_col;
  logic [1:0]       rd_col;
  logic             wr_fire;
  logic             rd_fire;
  logic [COL_W-1:0] perm;

  // Source column for row r of output column c; 2-bit arithmetic gives mod 4.
  function automatic logic [1:0] src_col(input logic [1:0] c, input logic [1:0] r);
    return INVERSE ? (c - r) : (c + r);
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Row-wise gather from the read bank; gated to zero when nothing is presented.
  always_comb begin
    perm = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      perm[COL_W-1-BYTE_W*r -: BYTE_W] =
        bank[rd_bank][src_col(rd_col, 2'(r))][COL_W-1-BYTE_W*r -: BYTE_W];
    end
  end

  assign col_out  = out_valid ? perm : '0;
  assign out_last = out_valid && (rd_col == 2'd3);

  // Bank storage, full flags and pointers; clr restores the reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        for (int unsigned c = 0; c < ROWS; c++) begin
          bank[b][c] <= '0;
        end
      end
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col  <= 2'd0;
      rd_col  <= 2'd0;
    end else if (clr) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        for (int unsigned c = 0; c < ROWS; c++) begin
          bank[b][c] <= '0;
        end
      end
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col  <= 2'd0;
      rd_col  <= 2'd0;
    end else begin
      if (wr_fire) begin
        bank[wr_bank][wr_col] <= col_in;
        wr_col                <= wr_col + 2'd1;
        if (wr_col == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      // Write and read sides always target different banks when both flip a flag.
      if (rd_fire) begin
        rd_col <= rd_col + 2'd1;
        if (rd_col == 2'd3) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Scoreboard bench for inv_shift_rows_serial: inverse/forward instances in
// parallel plus a forward->inverse round-trip chain.
module tb_inv_shift_rows_serial;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [31:0] col_in;
  logic        i_in_ready, i_out_valid, i_out_last;
  logic [31:0] i_col_out;
  logic        f_in_ready, f_out_valid, f_out_last;
  logic [31:0] f_col_out;
  logic        rt_in_valid, rt_out_ready;
  logic [31:0] rt_col_in;
  logic        a_in_ready, a_out_valid, a_out_last;
  logic [31:0] a_col_out;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [31:0] b_col_out;

  always #5 clk = ~clk;

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_inv (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(i_in_ready),
    .col_in(col_in), .out_valid(i_out_valid), .out_ready(out_ready),
    .col_out(i_col_out), .out_last(i_out_last));

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(f_in_ready),
    .col_in(col_in), .out_valid(f_out_valid), .out_ready(out_ready),
    .col_out(f_col_out), .out_last(f_out_last));

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_rt_fwd (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(rt_in_valid), .in_ready(a_in_ready),
    .col_in(rt_col_in), .out_valid(a_out_valid), .out_ready(b_in_ready),
    .col_out(a_col_out), .out_last(a_out_last));

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_rt_inv (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(a_out_valid), .in_ready(b_in_ready),
    .col_in(a_col_out), .out_valid(b_out_valid), .out_ready(rt_out_ready),
    .col_out(b_col_out), .out_last(b_out_last));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] iv;
    logic [31:0] fw;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [31:0] part[$];
  logic [31:0] q_rt[$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_col = '0;

  logic [31:0] vin   [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] exp_iv[4] = '{32'h000d0a07, 32'h04010e0b, 32'h0805020f, 32'h0c090603};
  logic [31:0] exp_fw[4] = '{32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output byte of row r in column c comes from input column c-r (inverse) or c+r.
  function automatic logic [31:0] model_col(input logic [31:0] b0, input logic [31:0] b1,
                                             input logic [31:0] b2, input logic [31:0] b3,
                                             input int c, input bit inv);
    logic [31:0] blk[4];
    logic [31:0] res;
    int src, sh;
    blk = '{b0, b1, b2, b3};
    res = '0;
    for (int r = 0; r < 4; r++) begin
      src = inv ? (c - r + 4) % 4 : (c + r) % 4;
      sh  = 24 - 8 * r;
      res = res | (((blk[src] >> sh) & 32'hff) << sh);
    end
    return res;
  endfunction

  // Monitor: checks presented outputs against the scoreboard, then records accepted inputs.
  always @(negedge clk) begin
    if (rst) begin
      q.delete(); part.delete(); q_rt.delete();
      hold_prev = 1'b0;
    end else begin
      chk1("fwd_valid_match", f_out_valid, i_out_valid);
      chk1("fwd_ready_match", f_in_ready, i_in_ready);
      if (hold_prev) begin
        chk1("hold_valid", i_out_valid, 1'b1);
        chk("hold_col", i_col_out, hold_col);
      end
      if (!i_out_valid) begin
        chk("idle_col", i_col_out, 32'h0);
        chk1("idle_last", i_out_last, 1'b0);
      end else if (out_ready && !clr) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got %08h expected none at %0t", i_col_out, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("inv_col", i_col_out, e.iv);
          chk("fwd_col", f_col_out, e.fw);
          chk1("inv_last", i_out_last, e.last);
          chk1("fwd_last", f_out_last, e.last);
        end
      end
      hold_prev = i_out_valid && !out_ready && !clr;
      hold_col  = i_col_out;
      if (clr) begin
        q.delete(); part.delete(); q_rt.delete();
      end else begin
        if (in_valid && i_in_ready) begin
          part.push_back(col_in);
          if (part.size() == 4) begin
            for (int c = 0; c < 4; c++) begin
              q.push_back('{iv: model_col(part[0], part[1], part[2], part[3], c, 1'b1),
                            fw: model_col(part[0], part[1], part[2], part[3], c, 1'b0),
                            last: (c == 3)});
            end
            part.delete();
          end
        end
        if (b_out_valid && rt_out_ready) begin
          if (q_rt.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rt_unexpected: got %08h expected none at %0t", b_col_out, $time);
          end else begin
            chk("rt_col", b_col_out, q_rt.pop_front());
          end
        end
        if (rt_in_valid && a_in_ready) q_rt.push_back(rt_col_in);
      end
    end
  end

  task automatic push_col(input logic [31:0] c);
    int  n = 0;
    bit  acc = 1'b0;
    in_valid = 1'b1;
    col_in   = c;
    do begin
      @(negedge clk); acc = i_in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic push_rt(input logic [31:0] c);
    int  n = 0;
    bit  acc = 1'b0;
    rt_in_valid = 1'b1;
    rt_col_in   = c;
    do begin
      @(negedge clk); acc = a_in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    rt_in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL rt_push_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  // Known-answer block on both instances, including fill latency and out_last.
  task automatic run_vec();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_col(vin[k]);
    chk1("latency_pre", i_out_valid, 1'b0);
    push_col(vin[3]);
    chk1("latency_post", i_out_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("vec_inv", i_col_out, exp_iv[k]);
      chk("vec_fwd", f_col_out, exp_fw[k]);
      chk1("vec_last", i_out_last, k == 3);
    end
    @(posedge clk); #1;
    chk1("vec_done_valid", i_out_valid, 1'b0);
  endtask

  bit done = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc_n;
    int n;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; col_in = '0; out_ready = 1'b0;
    rt_in_valid = 1'b0; rt_col_in = '0; rt_out_ready = 1'b1;
    #1;
    chk1("rst_in_ready", i_in_ready, 1'b1);
    chk1("rst_out_valid", i_out_valid, 1'b0);
    chk("rst_col_out", i_col_out, 32'h0);
    chk1("rst_out_last", i_out_last, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_vec();

    // Round trip: three back-to-back random blocks through forward then inverse.
    fork
      begin
        for (int i = 0; i < 12; i++) push_rt($urandom);
      end
      begin
        int w = 0;
        while (!b_out_valid && w < 100) begin @(negedge clk); w++; end
        for (int k = 0; k < 12; k++) begin
          chk1("rt_no_bubble", b_out_valid, 1'b1);
          if (k < 11) @(negedge clk);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rt_drained", 32'(q_rt.size()), 32'd0);

    // Backpressure: both banks fill, the ninth offer is refused.
    out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      col_in   = (i < 4) ? vin[i] : $urandom;
      @(negedge clk);
      if (i_in_ready) acc_n++;
      if (i >= 8) chk1("bp_in_ready_low", i_in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc_n), 32'd8);
    chk("bp_hold_inv", i_col_out, 32'h000d0a07);
    chk("bp_hold_fwd", f_col_out, 32'h00050a0f);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk1("bp_last", i_out_last, 1'b1);
    chk1("bp_ready_still_low", i_in_ready, 1'b0);
    @(negedge clk);
    chk1("bp_ready_reassert", i_in_ready, 1'b1);
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(posedge clk); #1;
    chk1("bp_empty_valid", i_out_valid, 1'b0);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // clr mid-block discards the partial block and the column offered with it.
    push_col($urandom);
    push_col($urandom);
    clr = 1'b1; in_valid = 1'b1; col_in = $urandom;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk1("clr_out_valid", i_out_valid, 1'b0);
    chk1("clr_in_ready", i_in_ready, 1'b1);
    for (int k = 0; k < 4; k++) push_col($urandom);
    chk1("clr_new_block_valid", i_out_valid, 1'b1);
    for (int k = 0; k < 4; k++) @(negedge clk);
    @(posedge clk); #1;
    chk("clr_drained", 32'(q.size()), 32'd0);
    chk1("clr_done_valid", i_out_valid, 1'b0);

    // Asynchronous reset between edges while a block is presented.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_col($urandom);
    chk1("arst_pre_valid", i_out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("arst_out_valid", i_out_valid, 1'b0);
    chk("arst_col_out", i_col_out, 32'h0);
    chk1("arst_out_last", i_out_last, 1'b0);
    chk1("arst_in_ready", i_in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec();

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 148; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          push_col($urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
